if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- Instruction fetch stage that drives the IF_ID pipeline register feeding the decode/controller stage.
- Owns the PC and issues pipelined requests to instruction memory over a request/grant plus response-valid handshake.
- Buffers returned instructions in a small in-order prefetch FIFO.
- Presents IF_ID_instruction, IF_ID_npc and IF_ID_valid to decode, with stall hold and branch-redirect flush.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries and the cap on in-flight requests (must be 2 or more).
- NOP_INSTR, 32'h00000013, word driven on IF_ID_instruction when invalid (addi x0,x0,0, I_type opcode).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (current PC, word aligned).
- imem_gnt  in  1  request accepted this cycle (only meaningful when imem_req=1).
- imem_rvalid  in  1  response data valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode cannot accept; hold the IF_ID outputs.
- redirect  in  1  branch taken; flush and refetch.
- redirect_pc  in  32  new fetch address.
- IF_ID_instruction  out  32  instruction presented to decode.
- IF_ID_npc  out  32  PC of that instruction + 4.
- IF_ID_valid  out  1  IF_ID contents are a real instruction.

Behaviour:
- Reset: synchronous active-low; clk and rst_n as above. When rst_n=0 at a rising edge:
  - pc=RESET_PC; FIFO empty; outstanding=0; discard_cnt=0.
  - IF_ID_valid=0, IF_ID_instruction=NOP_INSTR, IF_ID_npc=0.
  - imem_req=0 during the reset cycle.
  - Reset mid-operation discards everything. Responses for requests granted before reset are not tracked; the bench must not return them.
- Counters: outstanding counts granted-but-unreturned requests, including those pending discard. occ is the FIFO occupancy.
- Issue: imem_req=1 iff rst_n=1, redirect=0 and occ+outstanding<DEPTH (combinational).
  - imem_addr=pc.
  - req&&gnt: pc<=pc+4, outstanding increments.
  - The credit rule guarantees the FIFO never overflows; no overflow path is required.
- Response: on imem_rvalid, outstanding decrements.
  - If discard_cnt>0: drop the data and decrement discard_cnt.
  - Otherwise push {imem_rdata, fetch_pc+4} into the FIFO. The PC of each in-flight request is tracked by a small in-order PC queue or equivalent.
  - Grant and rvalid in the same cycle: net outstanding change is 0.
  - rvalid with outstanding=0 is a protocol error: ignore it and flag it with an assertion.
- IF_ID register, priority redirect > stall > advance:
  - redirect=1: IF_ID_valid<=0, IF_ID_instruction<=NOP_INSTR. FIFO cleared.
  - redirect=1: discard_cnt<=outstanding-(imem_rvalid?1:0)+discard_cnt_after_this_cycle_adjust. Net effect: every request granted before the redirect edge is dropped, including a response arriving in the redirect cycle.
  - redirect=1: pc<={redirect_pc[31:2],2'b00}; no request is issued that cycle.
  - stall=1: IF_ID outputs hold; FIFO does not pop.
  - stall=0, FIFO non-empty: load the head into IF_ID (valid=1), pop.
  - stall=0, FIFO empty: IF_ID_valid<=0, instruction<=NOP_INSTR, npc holds.
  - A FIFO push and pop in the same cycle is legal; occ is unchanged.
- Latency:
  - Grant at cycle t, response at t+L: word enters the FIFO at the end of t+L.
  - With no stall, it appears on IF_ID at the end of t+L+1.
  - Steady state with L=1, DEPTH=2: one instruction per cycle.
- Wrap-around: pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0) with no error.
- Stall and redirect together: redirect wins; the flush happens.

Test Plan:
- Reset then run, memory L=1 always granting, rdata=addr|32'hA0000000:
  - IF_ID_valid rises at cycle 3.
  - Instructions 32'hA0000000, A0000004, A0000008 appear on consecutive cycles.
  - IF_ID_npc=4, 8, 12.
- stall=1 for 5 cycles mid-stream:
  - IF_ID held constant.
  - imem_req drops once occ+outstanding=2.
  - After release the sequence resumes with no skipped or duplicated address.
- Memory L=3 with 1 outstanding at redirect (redirect_pc=32'h100):
  - The late response for the old address is dropped.
  - The next valid IF_ID is the word for 32'h100 with npc=32'h104.
- redirect and stall asserted together:
  - IF_ID_valid=0 and instruction=32'h00000013 the next cycle.
  - No FIFO entry survives.
- rst_n=0 while 2 requests are outstanding:
  - All outputs return to reset values next edge; imem_req=0.
  - First request after release has imem_addr=RESET_PC.
- redirect_pc=32'hFFFFFFFE:
  - Fetch addresses are FFFFFFFC then 00000000.
  - IF_ID_npc=0 for the FFFFFFFC word.

Source files
------------

// File: rtl/if_id_fetch_stage_if.sv
// Instruction memory bus: request/grant for addresses, in-order rvalid/rdata responses.
// The fetch stage is the master; the memory (or its model) is the slave.
interface if_id_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC, credit-limited imem requests, in-order prefetch FIFO, IF_ID register.
// Word reaches IF_ID one cycle after its response; stall holds IF_ID, redirect flushes and refetches.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    if_id_fetch_stage_if.master        imem,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                IF_ID_instruction,
    output logic [31:0]                IF_ID_npc,
    output logic                       IF_ID_valid
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, occ_q, occ_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_npc_q   [DEPTH];
    logic [31:0]   fifo_npc_d   [DEPTH];
    logic [31:0]   pq_npc_q     [DEPTH];
    logic [31:0]   pq_npc_d     [DEPTH];
    logic [31:0]   instr_q, instr_d, npc_q, npc_d;
    logic          valid_q, valid_d;
    logic          rvalid_ok, grant, push, pop;
    logic [CW:0]   inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The head leaving for IF_ID this cycle frees its slot, which keeps L=1 at one word per cycle.
    assign rvalid_ok      = imem.imem_rvalid && (out_q != '0);
    assign pop            = !redirect && !stall && (occ_q != '0);
    assign push           = rvalid_ok && (disc_q == '0) && !redirect;
    assign inflight       = {1'b0, occ_q} + {1'b0, out_q} - (CW+1)'(pop);
    assign imem.imem_req  = rst_n && !redirect && (inflight < (CW+1)'(DEPTH));
    assign imem.imem_addr = pc_q;
    assign grant          = imem.imem_req && imem.imem_gnt;

    always_comb begin
        pc_d         = pc_q;
        disc_d       = disc_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        pq_wr_d      = pq_wr_q;
        pq_rd_d      = pq_rd_q;
        fifo_instr_d = fifo_instr_q;
        fifo_npc_d   = fifo_npc_q;
        pq_npc_d     = pq_npc_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        valid_d      = valid_q;
        out_d        = out_q + CW'(grant) - CW'(rvalid_ok);
        occ_d        = occ_q + CW'(push) - CW'(pop);

        if (grant) begin
            pc_d              = pc_q + 32'd4;
            pq_npc_d[pq_wr_q] = pc_q + 32'd4;
            pq_wr_d           = ptr_inc(pq_wr_q);
        end
        // Every response retires a PC-queue entry, whether kept or discarded.
        if (rvalid_ok) begin
            pq_rd_d = ptr_inc(pq_rd_q);
        end
        if (rvalid_ok && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end
        if (push) begin
            fifo_instr_d[wr_q] = imem.imem_rdata;
            fifo_npc_d[wr_q]   = pq_npc_q[pq_rd_q];
            wr_d               = ptr_inc(wr_q);
        end
        if (pop) begin
            instr_d = fifo_instr_q[rd_q];
            npc_d   = fifo_npc_q[rd_q];
            valid_d = 1'b1;
            rd_d    = ptr_inc(rd_q);
        end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
        // Whatever is still in flight after this edge belongs to the old path.
        if (redirect) begin
            pc_d    = redirect_pc & ~32'h3;
            disc_d  = out_d;
            occ_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        fifo_instr_q <= fifo_instr_d;
        fifo_npc_q   <= fifo_npc_d;
        pq_npc_q     <= pq_npc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
            occ_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            pq_wr_q <= '0;
            pq_rd_q <= '0;
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            occ_q   <= occ_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            pq_wr_q <= pq_wr_d;
            pq_rd_q <= pq_rd_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign IF_ID_instruction = instr_q;
    assign IF_ID_npc         = npc_q;
    assign IF_ID_valid       = valid_q;

    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem.imem_rvalid |-> (out_q != '0));
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench: directed scenarios push expected IF_ID words; a monitor pops on each consumed word.
module tb_if_id_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IF_ID_instruction, IF_ID_npc;
    logic        IF_ID_valid;

    always #5 clk = ~clk;

    if_id_fetch_stage_if bus();

    if_id_fetch_stage #(.RESET_PC(RST_PC), .DEPTH(2), .NOP_INSTR(NOP)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem              (bus),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_npc         (IF_ID_npc),
        .IF_ID_valid       (IF_ID_valid)
    );

    typedef struct packed { logic [31:0] instr; logic [31:0] npc; } exp_t;
    typedef struct packed { logic [31:0] addr;  logic [31:0] due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cons = 0;
    int unsigned lat = 1;
    int unsigned cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = start + 32'(4 * i);
            exp_q.push_back('{a | 32'hA000_0000, a + 32'd4});
        end
    endtask

    task automatic wait_cons(input int target, input string name);
        int k;
        k = 0;
        while (n_cons < target && k < 60) begin
            step();
            k++;
        end
        n_cmp++;
        if (n_cons < target) begin
            n_bad++;
            $display("FAIL %s: consumed %0d words, required %0d", name, n_cons, target);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        step();
        step();
        push_seq(RST_PC, 40);
        rst_n = 1'b1;
    endtask

    // Memory model: always grants, answers in order lat cycles later with addr|A0000000.
    initial begin
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            step();
            cyc++;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = pend_q[0].addr | 32'hA000_0000;
                void'(pend_q.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (!rst_n)
                pend_q.delete();
            else if (bus.imem_req && bus.imem_gnt)
                pend_q.push_back('{bus.imem_addr, cyc + lat});
        end
    end

    // Monitor: decode takes IF_ID when valid and neither stalled nor flushed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && IF_ID_valid && !stall && !redirect) begin
                n_cons++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %h, expected no word", IF_ID_instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("if_id_instruction", IF_ID_instruction, e.instr);
                    check("if_id_npc", IF_ID_npc, e.npc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_i, held_n;
        int          base;
        bit          found;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset state, then streaming with L=1
        step();
        @(negedge clk);
        check("rst_valid", 32'(IF_ID_valid), 32'd0);
        check("rst_instr", IF_ID_instruction, NOP);
        check("rst_npc", IF_ID_npc, 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        step();
        rst_n = 1'b1;
        push_seq(RST_PC, 40);
        @(negedge clk);
        check("c0_req", 32'(bus.imem_req), 32'd1);
        check("c0_addr", bus.imem_addr, RST_PC);
        check("c0_valid", 32'(IF_ID_valid), 32'd0);
        step(); @(negedge clk); check("c1_valid", 32'(IF_ID_valid), 32'd0);
        step(); @(negedge clk); check("c2_valid", 32'(IF_ID_valid), 32'd0);
        step(); @(negedge clk); check("c3_valid", 32'(IF_ID_valid), 32'd1);
        step(); @(negedge clk); check("c4_valid", 32'(IF_ID_valid), 32'd1);
        step(); @(negedge clk); check("c5_valid", 32'(IF_ID_valid), 32'd1);

        // Stall for 5 cycles mid-stream
        step(); step();
        step();
        stall = 1'b1;
        @(negedge clk);
        held_i = IF_ID_instruction;
        held_n = IF_ID_npc;
        check("stall_valid", 32'(IF_ID_valid), 32'd1);
        check("stall_req_drop", 32'(bus.imem_req), 32'd0);
        for (int k = 1; k < 5; k++) begin
            step();
            @(negedge clk);
            check("stall_hold_instr", IF_ID_instruction, held_i);
            check("stall_hold_npc", IF_ID_npc, held_n);
            check("stall_hold_valid", 32'(IF_ID_valid), 32'd1);
            check("stall_req_low", 32'(bus.imem_req), 32'd0);
        end
        step();
        stall = 1'b0;
        base = n_cons;
        wait_cons(base + 4, "stall_resume");

        // Redirect with L=3 while one request is outstanding
        lat = 3;
        do_reset();
        repeat (5) step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        exp_q.delete();
        push_seq(32'h0000_0100, 40);
        @(negedge clk);
        check("redirect_no_req", 32'(bus.imem_req), 32'd0);
        step();
        redirect = 1'b0;
        base = n_cons;
        wait_cons(base + 2, "redirect_refetch");

        // Redirect and stall together
        lat = 1;
        repeat (8) step();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        exp_q.delete();
        push_seq(32'h0000_0200, 40);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(IF_ID_valid), 32'd0);
        check("flush_instr", IF_ID_instruction, NOP);
        step();
        @(negedge clk);
        check("flush_stall_valid", 32'(IF_ID_valid), 32'd0);
        step();
        stall = 1'b0;
        base = n_cons;
        wait_cons(base + 3, "flush_resume");

        // Reset while two requests are outstanding
        lat = 3;
        base = n_cons;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #2;
            if (n_cons >= base + 1 && (pend_q.size() + (bus.imem_rvalid ? 1 : 0)) == 2)
                found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL two_outstanding: found %0d, expected 1", found);
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_req", 32'(bus.imem_req), 32'd0);
        step();
        @(negedge clk);
        check("midrst_valid", 32'(IF_ID_valid), 32'd0);
        check("midrst_instr", IF_ID_instruction, NOP);
        check("midrst_npc", IF_ID_npc, 32'd0);
        check("midrst_req_held", 32'(bus.imem_req), 32'd0);
        step();
        rst_n = 1'b1;
        push_seq(RST_PC, 40);
        @(negedge clk);
        check("postrst_req", 32'(bus.imem_req), 32'd1);
        check("postrst_addr", bus.imem_addr, RST_PC);
        base = n_cons;
        wait_cons(base + 2, "postrst_stream");

        // Wrap-around through a misaligned redirect target
        lat = 1;
        repeat (8) step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        exp_q.delete();
        push_seq(32'hFFFF_FFFC, 40);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_req0", 32'(bus.imem_req), 32'd1);
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("wrap_req1", 32'(bus.imem_req), 32'd1);
        check("wrap_addr1", bus.imem_addr, 32'h0000_0000);
        base = n_cons;
        wait_cons(base + 3, "wrap_stream");

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
